// File: rtl/branch_pkg.sv
// ---------------------------------------------------------------------------
// branch_pkg
// Shared definitions for the branch-evaluation unit:
//   - RISC-V conditional-branch funct3 encodings
//   - is_legal_branch(): true for the six defined branch encodings
//   - PC_STEP: sequential instruction stride used for the fall-through PC
// ---------------------------------------------------------------------------
package branch_pkg;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam int unsigned PC_STEP = 4;

    // Only 010 and 011 are unassigned in the branch opcode space.
    function automatic logic is_legal_branch(input logic [2:0] f3);
        return (f3 != 3'b010) && (f3 != 3'b011);
    endfunction

endpackage

// File: rtl/branch_cmp.sv
// ---------------------------------------------------------------------------
// branch_cmp
// Purely combinational branch condition evaluation.
// Ports:
//   funct3  in   branch type (BEQ/BNE/BLT/BGE/BLTU/BGEU)
//   rs1     in   operand A (XLEN)
//   rs2     in   operand B (XLEN)
//   taken   out  branch condition true (always 0 for an illegal funct3)
//   illegal out  funct3 is not a defined branch encoding
// ---------------------------------------------------------------------------
module branch_cmp #(
    parameter int XLEN = 32
) (
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            taken,
    output logic            illegal
);
    import branch_pkg::*;

    logic signed [XLEN-1:0] rs1_s;
    logic signed [XLEN-1:0] rs2_s;
    logic                   eq;
    logic                   lt_s;
    logic                   lt_u;

    assign rs1_s = rs1;
    assign rs2_s = rs2;

    always_comb begin
        eq      = (rs1 == rs2);
        lt_s    = (rs1_s < rs2_s);
        lt_u    = (rs1 < rs2);
        illegal = !is_legal_branch(funct3);
        taken   = 1'b0;
        case (funct3)
            F3_BEQ:  taken = eq;
            F3_BNE:  taken = !eq;
            F3_BLT:  taken = lt_s;
            F3_BGE:  taken = !lt_s;
            F3_BLTU: taken = lt_u;
            F3_BGEU: taken = !lt_u;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_unit_pipe.sv
// ---------------------------------------------------------------------------
// branch_unit_pipe
// Registered branch-evaluation stage with a valid/ready handshake and one
// cycle of latency. A single output register holds the result; a new
// request is accepted whenever that register is empty or being drained.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   in_valid/in_ready          request handshake
//   funct3, rs1, rs2, pc, imm  branch request fields
//   out_valid/out_ready        result handshake
//   out_taken, out_illegal     branch decision, undefined-funct3 flag
//   out_target, out_next_pc    pc+sext(imm), and resolved next PC
//   led_n                      active-low: 0 when the last legal branch was taken
//   clr_cnt                    synchronous clear of both statistics counters
//   taken_cnt, not_taken_cnt   saturating branch statistics
// ---------------------------------------------------------------------------
module branch_unit_pipe #(
    parameter int XLEN  = 32,
    parameter int IMM_W = 13,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        funct3,
    input  logic [XLEN-1:0]   rs1,
    input  logic [XLEN-1:0]   rs2,
    input  logic [XLEN-1:0]   pc,
    input  logic [IMM_W-1:0]  imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_taken,
    output logic              out_illegal,
    output logic [XLEN-1:0]   out_target,
    output logic [XLEN-1:0]   out_next_pc,
    output logic              led_n,
    input  logic              clr_cnt,
    output logic [CNT_W-1:0]  taken_cnt,
    output logic [CNT_W-1:0]  not_taken_cnt
);
    import branch_pkg::*;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    logic                    accept;
    logic                    cmp_taken;
    logic                    cmp_illegal;
    logic signed [IMM_W-1:0] imm_s;
    logic signed [XLEN-1:0]  imm_sext;
    logic [XLEN-1:0]         target;
    logic [XLEN-1:0]         pc_plus4;

    logic                    out_valid_q,   out_valid_d;
    logic                    out_taken_q,   out_taken_d;
    logic                    out_illegal_q, out_illegal_d;
    logic [XLEN-1:0]         out_target_q,  out_target_d;
    logic [XLEN-1:0]         out_next_pc_q, out_next_pc_d;
    logic                    led_n_q,       led_n_d;
    logic [CNT_W-1:0]        taken_cnt_q,   taken_cnt_d;
    logic [CNT_W-1:0]        nt_cnt_q,      nt_cnt_d;

    branch_cmp #(.XLEN(XLEN)) u_cmp (
        .funct3  (funct3),
        .rs1     (rs1),
        .rs2     (rs2),
        .taken   (cmp_taken),
        .illegal (cmp_illegal)
    );

    // Both adders wrap modulo 2^XLEN; bit 0 of the immediate is kept as given.
    assign imm_s    = imm;
    assign imm_sext = XLEN'(imm_s);
    assign target   = pc + $unsigned(imm_sext);
    assign pc_plus4 = pc + XLEN'(PC_STEP);

    assign in_ready = ~out_valid_q | out_ready;
    assign accept   = in_valid & in_ready;

    always_comb begin
        out_valid_d   = out_valid_q;
        out_taken_d   = out_taken_q;
        out_illegal_d = out_illegal_q;
        out_target_d  = out_target_q;
        out_next_pc_d = out_next_pc_q;
        led_n_d       = led_n_q;
        taken_cnt_d   = taken_cnt_q;
        nt_cnt_d      = nt_cnt_q;

        if (accept) begin
            out_valid_d   = 1'b1;
            out_taken_d   = cmp_taken;
            out_illegal_d = cmp_illegal;
            out_target_d  = target;
            out_next_pc_d = cmp_taken ? target : pc_plus4;
            // Illegal encodings leave the LED and statistics untouched.
            if (!cmp_illegal) begin
                led_n_d = ~cmp_taken;
                if (cmp_taken) taken_cnt_d = sat_inc(taken_cnt_q);
                else           nt_cnt_d    = sat_inc(nt_cnt_q);
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end

        // Clear wins over a same-cycle increment.
        if (clr_cnt) begin
            taken_cnt_d = '0;
            nt_cnt_d    = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q   <= 1'b0;
            out_taken_q   <= 1'b0;
            out_illegal_q <= 1'b0;
            out_target_q  <= '0;
            out_next_pc_q <= '0;
            led_n_q       <= 1'b1;
            taken_cnt_q   <= '0;
            nt_cnt_q      <= '0;
        end else begin
            out_valid_q   <= out_valid_d;
            out_taken_q   <= out_taken_d;
            out_illegal_q <= out_illegal_d;
            out_target_q  <= out_target_d;
            out_next_pc_q <= out_next_pc_d;
            led_n_q       <= led_n_d;
            taken_cnt_q   <= taken_cnt_d;
            nt_cnt_q      <= nt_cnt_d;
        end
    end

    assign out_valid     = out_valid_q;
    assign out_taken     = out_taken_q;
    assign out_illegal   = out_illegal_q;
    assign out_target    = out_target_q;
    assign out_next_pc   = out_next_pc_q;
    assign led_n         = led_n_q;
    assign taken_cnt     = taken_cnt_q;
    assign not_taken_cnt = nt_cnt_q;

endmodule

// File: tb/tb_branch_unit_pipe.sv
// ---------------------------------------------------------------------------
// tb_branch_unit_pipe
// Directed testbench for branch_unit_pipe (XLEN=32, IMM_W=13, CNT_W=2).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_branch_unit_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  funct3;
    logic [31:0] rs1, rs2, pc;
    logic [12:0] imm;
    logic        out_valid;
    logic        out_ready;
    logic        out_taken;
    logic        out_illegal;
    logic [31:0] out_target;
    logic [31:0] out_next_pc;
    logic        led_n;
    logic        clr_cnt;
    logic [1:0]  taken_cnt;
    logic [1:0]  not_taken_cnt;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    branch_unit_pipe #(.XLEN(32), .IMM_W(13), .CNT_W(2)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .funct3        (funct3),
        .rs1           (rs1),
        .rs2           (rs2),
        .pc            (pc),
        .imm           (imm),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_taken     (out_taken),
        .out_illegal   (out_illegal),
        .out_target    (out_target),
        .out_next_pc   (out_next_pc),
        .led_n         (led_n),
        .clr_cnt       (clr_cnt),
        .taken_cnt     (taken_cnt),
        .not_taken_cnt (not_taken_cnt)
    );

    // Present one request at the current falling edge, let one rising edge
    // pass, then withdraw it at the following falling edge.
    task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] p, input logic [12:0] im);
        funct3 = f3; rs1 = a; rs2 = b; pc = p; imm = im; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic clear_counters();
        clr_cnt = 1'b1;
        @(negedge clk);
        clr_cnt = 1'b0;
    endtask

    task automatic test_reset();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
        n_cmp++; if (out_taken !== 1'b0) begin n_err++; $display("FAIL rst_out_taken: got %b want 0", out_taken); end
        n_cmp++; if (out_illegal !== 1'b0) begin n_err++; $display("FAIL rst_out_illegal: got %b want 0", out_illegal); end
        n_cmp++; if (out_target !== 32'h0) begin n_err++; $display("FAIL rst_out_target: got %h want 0", out_target); end
        n_cmp++; if (out_next_pc !== 32'h0) begin n_err++; $display("FAIL rst_out_next_pc: got %h want 0", out_next_pc); end
        n_cmp++; if (led_n !== 1'b1) begin n_err++; $display("FAIL rst_led_n: got %b want 1", led_n); end
        n_cmp++; if (taken_cnt !== 2'd0) begin n_err++; $display("FAIL rst_taken_cnt: got %0d want 0", taken_cnt); end
        n_cmp++; if (not_taken_cnt !== 2'd0) begin n_err++; $display("FAIL rst_nt_cnt: got %0d want 0", not_taken_cnt); end
    endtask

    task automatic test_compare();
        out_ready = 1'b1;
        // BEQ 5 == 5 -> taken, target 0x120
        issue(3'b000, 32'd5, 32'd5, 32'h100, 13'h020);
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL beq_valid: got %b want 1", out_valid); end
        n_cmp++; if (out_taken !== 1'b1) begin n_err++; $display("FAIL beq_taken: got %b want 1", out_taken); end
        n_cmp++; if (out_target !== 32'h120) begin n_err++; $display("FAIL beq_target: got %h want 120", out_target); end
        n_cmp++; if (out_next_pc !== 32'h120) begin n_err++; $display("FAIL beq_next_pc: got %h want 120", out_next_pc); end
        n_cmp++; if (led_n !== 1'b0) begin n_err++; $display("FAIL beq_led_n: got %b want 0", led_n); end
        n_cmp++; if (taken_cnt !== 2'd1) begin n_err++; $display("FAIL beq_taken_cnt: got %0d want 1", taken_cnt); end
        // BLT -1 < 1 signed -> taken, negative offset -16: 0x100 - 0x10 = 0xF0
        issue(3'b100, 32'hFFFF_FFFF, 32'd1, 32'h100, 13'h1FF0);
        n_cmp++; if (out_taken !== 1'b1) begin n_err++; $display("FAIL blt_taken: got %b want 1", out_taken); end
        n_cmp++; if (out_next_pc !== 32'h0F0) begin n_err++; $display("FAIL blt_next_pc: got %h want f0", out_next_pc); end
        // BLTU 0xFFFFFFFF < 1 unsigned -> not taken
        issue(3'b110, 32'hFFFF_FFFF, 32'd1, 32'h100, 13'h020);
        n_cmp++; if (out_taken !== 1'b0) begin n_err++; $display("FAIL bltu_taken: got %b want 0", out_taken); end
        n_cmp++; if (out_next_pc !== 32'h104) begin n_err++; $display("FAIL bltu_next_pc: got %h want 104", out_next_pc); end
        n_cmp++; if (out_target !== 32'h120) begin n_err++; $display("FAIL bltu_target: got %h want 120", out_target); end
        n_cmp++; if (led_n !== 1'b1) begin n_err++; $display("FAIL bltu_led_n: got %b want 1", led_n); end
        n_cmp++; if (not_taken_cnt !== 2'd1) begin n_err++; $display("FAIL bltu_nt_cnt: got %0d want 1", not_taken_cnt); end
        // BGE 7 >= 7 -> taken on equality
        issue(3'b101, 32'd7, 32'd7, 32'h200, 13'h008);
        n_cmp++; if (out_taken !== 1'b1) begin n_err++; $display("FAIL bge_taken: got %b want 1", out_taken); end
        n_cmp++; if (out_next_pc !== 32'h208) begin n_err++; $display("FAIL bge_next_pc: got %h want 208", out_next_pc); end
        // BGEU 3 >= 9 unsigned -> not taken
        issue(3'b111, 32'd3, 32'd9, 32'h200, 13'h008);
        n_cmp++; if (out_taken !== 1'b0) begin n_err++; $display("FAIL bgeu_taken: got %b want 0", out_taken); end
        // BNE 1 != 5 -> taken; taken count 1,2,3 then saturates at 3
        issue(3'b001, 32'd1, 32'd5, 32'h300, 13'h010);
        n_cmp++; if (out_taken !== 1'b1) begin n_err++; $display("FAIL bne_taken: got %b want 1", out_taken); end
        n_cmp++; if (led_n !== 1'b0) begin n_err++; $display("FAIL bne_led_n: got %b want 0", led_n); end
        n_cmp++; if (taken_cnt !== 2'd3) begin n_err++; $display("FAIL bne_taken_cnt: got %0d want 3", taken_cnt); end
        n_cmp++; if (not_taken_cnt !== 2'd2) begin n_err++; $display("FAIL bne_nt_cnt: got %0d want 2", not_taken_cnt); end
        // One idle cycle with out_ready=1 drains the result
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL drain_valid: got %b want 0", out_valid); end
    endtask

    task automatic test_illegal();
        // Previous legal branch was taken (led_n=0, taken=3, nt=2)
        issue(3'b010, 32'd4, 32'd4, 32'h200, 13'h040);
        n_cmp++; if (out_illegal !== 1'b1) begin n_err++; $display("FAIL ill_flag: got %b want 1", out_illegal); end
        n_cmp++; if (out_taken !== 1'b0) begin n_err++; $display("FAIL ill_taken: got %b want 0", out_taken); end
        n_cmp++; if (out_next_pc !== 32'h204) begin n_err++; $display("FAIL ill_next_pc: got %h want 204", out_next_pc); end
        n_cmp++; if (out_target !== 32'h240) begin n_err++; $display("FAIL ill_target: got %h want 240", out_target); end
        n_cmp++; if (led_n !== 1'b0) begin n_err++; $display("FAIL ill_led_n: got %b want 0", led_n); end
        n_cmp++; if (taken_cnt !== 2'd3) begin n_err++; $display("FAIL ill_taken_cnt: got %0d want 3", taken_cnt); end
        n_cmp++; if (not_taken_cnt !== 2'd2) begin n_err++; $display("FAIL ill_nt_cnt: got %0d want 2", not_taken_cnt); end
        issue(3'b011, 32'd1, 32'd2, 32'h200, 13'h040);
        n_cmp++; if (out_illegal !== 1'b1) begin n_err++; $display("FAIL ill011_flag: got %b want 1", out_illegal); end
        // A following legal branch clears the illegal flag
        issue(3'b000, 32'd1, 32'd1, 32'h200, 13'h040);
        n_cmp++; if (out_illegal !== 1'b0) begin n_err++; $display("FAIL ill_clear: got %b want 0", out_illegal); end
    endtask

    task automatic test_wrap();
        clear_counters();
        // BNE not taken at the top of the address space: pc+4 wraps to 0
        issue(3'b001, 32'd9, 32'd9, 32'hFFFF_FFFC, 13'h008);
        n_cmp++; if (out_next_pc !== 32'h0) begin n_err++; $display("FAIL wrap_next_pc: got %h want 0", out_next_pc); end
        n_cmp++; if (out_target !== 32'h4) begin n_err++; $display("FAIL wrap_target: got %h want 4", out_target); end
        n_cmp++; if (led_n !== 1'b1) begin n_err++; $display("FAIL wrap_led_n: got %b want 1", led_n); end
        n_cmp++; if (not_taken_cnt !== 2'd1) begin n_err++; $display("FAIL wrap_nt_cnt: got %0d want 1", not_taken_cnt); end
    endtask

    task automatic test_saturation();
        clear_counters();
        n_cmp++; if (taken_cnt !== 2'd0) begin n_err++; $display("FAIL clr_taken_cnt: got %0d want 0", taken_cnt); end
        n_cmp++; if (not_taken_cnt !== 2'd0) begin n_err++; $display("FAIL clr_nt_cnt: got %0d want 0", not_taken_cnt); end
        // Five back-to-back taken BEQs
        funct3 = 3'b000; rs1 = 32'd2; rs2 = 32'd2; pc = 32'h40; imm = 13'h004; in_valid = 1'b1;
        repeat (5) @(negedge clk);
        in_valid = 1'b0;
        n_cmp++; if (taken_cnt !== 2'd3) begin n_err++; $display("FAIL sat_taken_cnt: got %0d want 3", taken_cnt); end
        // Clear coincident with a taken accept: clear wins
        clr_cnt = 1'b1;
        issue(3'b000, 32'd2, 32'd2, 32'h40, 13'h004);
        clr_cnt = 1'b0;
        n_cmp++; if (taken_cnt !== 2'd0) begin n_err++; $display("FAIL clr_prio_cnt: got %0d want 0", taken_cnt); end
        n_cmp++; if (out_taken !== 1'b1) begin n_err++; $display("FAIL clr_prio_taken: got %b want 1", out_taken); end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        clear_counters();
        out_ready = 1'b0;
        // Request A
        funct3 = 3'b000; rs1 = 32'd1; rs2 = 32'd1; pc = 32'h300; imm = 13'h010; in_valid = 1'b1;
        @(negedge clk);
        // Request B waits with in_valid held
        pc = 32'h400;
        for (int c = 0; c < 3; c++) begin
            n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready[%0d]: got %b want 0", c, in_ready); end
            n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_valid[%0d]: got %b want 1", c, out_valid); end
            n_cmp++; if (out_target !== 32'h310) begin n_err++; $display("FAIL bp_target[%0d]: got %h want 310", c, out_target); end
            @(negedge clk);
        end
        n_cmp++; if (taken_cnt !== 2'd1) begin n_err++; $display("FAIL bp_one_result: got %0d want 1", taken_cnt); end
        // Release: B is accepted in this same cycle
        out_ready = 1'b1;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_release_ready: got %b want 1", in_ready); end
        @(negedge clk);
        in_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_b_valid: got %b want 1", out_valid); end
        n_cmp++; if (out_target !== 32'h410) begin n_err++; $display("FAIL bp_b_target: got %h want 410", out_target); end
        n_cmp++; if (taken_cnt !== 2'd2) begin n_err++; $display("FAIL bp_b_cnt: got %0d want 2", taken_cnt); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        funct3 = 3'b000; rs1 = 32'd0; rs2 = 32'd0; pc = 32'h1000; imm = 13'h008; in_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL b2b_valid[%0d]: got %b want 1", k, out_valid); end
            n_cmp++; if (out_target !== 32'h1008 + 32'(k * 16)) begin n_err++; $display("FAIL b2b_target[%0d]: got %h want %h", k, out_target, 32'h1008 + 32'(k * 16)); end
            if (k < 3) pc = 32'h1000 + 32'((k + 1) * 16);
            else       in_valid = 1'b0;
        end
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL b2b_done: got %b want 0", out_valid); end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        issue(3'b000, 32'd2, 32'd2, 32'h600, 13'h004);
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL rm_pending: got %b want 1", out_valid); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rm_valid: got %b want 0", out_valid); end
        n_cmp++; if (led_n !== 1'b1) begin n_err++; $display("FAIL rm_led_n: got %b want 1", led_n); end
        n_cmp++; if (taken_cnt !== 2'd0) begin n_err++; $display("FAIL rm_taken_cnt: got %0d want 0", taken_cnt); end
        n_cmp++; if (out_target !== 32'h0) begin n_err++; $display("FAIL rm_target: got %h want 0", out_target); end
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        issue(3'b000, 32'd3, 32'd3, 32'h500, 13'h004);
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL rm_new_valid: got %b want 1", out_valid); end
        n_cmp++; if (out_target !== 32'h504) begin n_err++; $display("FAIL rm_new_target: got %h want 504", out_target); end
        n_cmp++; if (taken_cnt !== 2'd1) begin n_err++; $display("FAIL rm_new_cnt: got %0d want 1", taken_cnt); end
        n_cmp++; if (led_n !== 1'b0) begin n_err++; $display("FAIL rm_new_led_n: got %b want 0", led_n); end
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; clr_cnt = 1'b0;
        funct3 = 3'b000; rs1 = '0; rs2 = '0; pc = '0; imm = '0;
        repeat (2) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        @(negedge clk);
        test_compare();
        test_illegal();
        test_wrap();
        test_saturation();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
